one2axi_master: RTL and testbench
=================================

Name: one2axi_master

Overview:
- Initiator-side bridge: takes single-word requests on the internal register bus (addr, wdata, wr/rd strobes) and issues them as AXI4-Lite master transactions.
- Other end of the AXI4-Lite link from the slave-side arbiter. Lets internal controllers (sequencers, DMA control) reach AXI-mapped peripherals.
- One outstanding transaction at a time. At most one read is buffered behind a write.

Parameters:
- ADDR_WIDTH, 32, width of req_addr, awaddr and araddr
- DATA_WIDTH, 32, width of the data paths; wstrb width is DATA_WIDTH/8

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- req_addr  in  ADDR_WIDTH  byte address of the request
- req_wdata  in  DATA_WIDTH  write data
- req_wr  in  1  write request strobe; sampled only when req_ready=1
- req_rd  in  1  read request strobe; sampled only when req_ready=1
- req_ready  out  1  bridge can accept a request this cycle
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  DATA_WIDTH  read data, valid with resp_valid on a read completion
- resp_resp  out  2  captured bresp or rresp
- resp_is_rd  out  1  1 = the completion is a read
- m_awaddr  out  ADDR_WIDTH  AXI write address
- m_awvalid  out  1  AXI write address valid
- m_awready  in  1  AXI write address ready
- m_wdata  out  DATA_WIDTH  AXI write data
- m_wstrb  out  DATA_WIDTH/8  AXI write strobes
- m_wvalid  out  1  AXI write data valid
- m_wready  in  1  AXI write data ready
- m_bresp  in  2  AXI write response
- m_bvalid  in  1  AXI write response valid
- m_bready  out  1  AXI write response ready
- m_araddr  out  ADDR_WIDTH  AXI read address
- m_arvalid  out  1  AXI read address valid
- m_arready  in  1  AXI read address ready
- m_rdata  in  DATA_WIDTH  AXI read data
- m_rresp  in  2  AXI read response
- m_rvalid  in  1  AXI read data valid
- m_rready  out  1  AXI read data ready

Behaviour:
- Reset values:
  - All m_*valid, m_bready, m_rready, resp_valid, resp_is_rd = 0.
  - m_awaddr, m_araddr, m_wdata, resp_rdata, resp_resp = 0.
  - m_wstrb = all ones.
  - State = IDLE, so req_ready = 1.
- req_ready = (state==IDLE) && !rd_pend. It is combinational from registers.
- States: IDLE, WR (AW/W phase), WB (B phase), RA (AR phase), RD (R phase).
- IDLE, req_wr=1 at edge N:
  - Latch addr and wdata.
  - m_awvalid = m_wvalid = 1 from cycle N+1; go to WR.
- IDLE, req_rd=1 only:
  - Latch addr; m_arvalid = 1 from N+1; go to RA.
- req_wr and req_rd both 1 in the same cycle:
  - The write executes first.
  - The read's address is held in a pending register (rd_pend=1).
  - After the write completes, the FSM goes directly to RA without returning through an accepting IDLE.
  - req_ready stays 0 throughout.
- WR:
  - m_awvalid drops the cycle after awvalid&awready; m_wvalid drops the cycle after wvalid&wready.
  - AW and W complete independently and in either order, including the same cycle.
  - Once both are done, assert m_bready and go to WB.
  - Valids never drop before their handshake.
  - Address and data are stable while valid.
- WB: on bvalid&bready:
  - Deassert bready.
  - Register resp_resp = m_bresp, resp_is_rd = 0, resp_valid = 1 for one cycle.
  - Go to IDLE, or to RA if rd_pend.
- RA: on arvalid&arready, deassert m_arvalid, assert m_rready, go to RD.
- RD: on rvalid&rready:
  - Capture m_rdata and m_rresp.
  - Set resp_is_rd = 1, resp_valid = 1 next cycle.
  - Clear rd_pend; go to IDLE.
- Minimum latency with always-ready slave responses:
  - Write: request edge N → resp_valid at N+3.
  - Read: same, N+3.
- Non-OKAY bresp/rresp values are passed through unchanged; the FSM continues normally.
- resp_rdata holds its value until the next read completion.
- No timeout: the bridge waits indefinitely for the slave.
- resetn low mid-transaction: all outputs return to reset values immediately (async); any pending read is discarded.

Test Plan:
- Write, always-ready slave: req_wr, addr 0x0000_0104, wdata 0x11223344 → awvalid and wvalid high one cycle with these values; bready high; resp_valid at N+3 with resp_resp=0, resp_is_rd=0.
- Read, arready delayed 4 cycles, rdata 0x55667788: arvalid held stable 5 cycles → resp_valid with resp_rdata=0x55667788, resp_is_rd=1.
- Write with wready 3 cycles before awready: wvalid drops first, awvalid held → exactly one B handshake, one resp_valid.
- req_wr and req_rd same cycle, addrs 0x108 / 0x10C: write completes, then arvalid with araddr=0x10C with no IDLE gap; req_ready=0 throughout; two resp_valid pulses, write then read.
- Slave returns bresp=2'b10, then rresp=2'b11: resp_resp=2 then 3; FSM back in IDLE, req_ready=1.
- resetn pulsed low while in RD with rvalid=0: all valids/readies 0 immediately; after release req_ready=1 and no resp_valid issued.

Source files
------------

// File: rtl/one2axi_master.sv
// Register-bus to AXI4-Lite master bridge: one outstanding transaction, with an
// optional read queued behind a write when both strobes arrive together.
module one2axi_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [ADDR_WIDTH-1:0]     req_addr,
  input  logic [DATA_WIDTH-1:0]     req_wdata,
  input  logic                      req_wr,
  input  logic                      req_rd,
  output logic                      req_ready,
  output logic                      resp_valid,
  output logic [DATA_WIDTH-1:0]     resp_rdata,
  output logic [1:0]                resp_resp,
  output logic                      resp_is_rd,
  output logic [ADDR_WIDTH-1:0]     m_awaddr,
  output logic                      m_awvalid,
  input  logic                      m_awready,
  output logic [DATA_WIDTH-1:0]     m_wdata,
  output logic [DATA_WIDTH/8-1:0]   m_wstrb,
  output logic                      m_wvalid,
  input  logic                      m_wready,
  input  logic [1:0]                m_bresp,
  input  logic                      m_bvalid,
  output logic                      m_bready,
  output logic [ADDR_WIDTH-1:0]     m_araddr,
  output logic                      m_arvalid,
  input  logic                      m_arready,
  input  logic [DATA_WIDTH-1:0]     m_rdata,
  input  logic [1:0]                m_rresp,
  input  logic                      m_rvalid,
  output logic                      m_rready
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [2:0] {IDLE, WR, WB, RA, RD} state_t;

  state_t                 state_reg, state_next;
  logic                   rd_pend_reg, rd_pend_next;
  logic [ADDR_WIDTH-1:0]  awaddr_reg, awaddr_next;
  logic [ADDR_WIDTH-1:0]  araddr_reg, araddr_next;
  logic [DATA_WIDTH-1:0]  wdata_reg, wdata_next;
  logic [DATA_WIDTH-1:0]  rdata_reg, rdata_next;
  logic                   awvalid_reg, awvalid_next;
  logic                   wvalid_reg, wvalid_next;
  logic                   bready_reg, bready_next;
  logic                   arvalid_reg, arvalid_next;
  logic                   rready_reg, rready_next;
  logic                   resp_valid_reg, resp_valid_next;
  logic                   resp_is_rd_reg, resp_is_rd_next;
  logic [1:0]             resp_resp_reg, resp_resp_next;
  logic                   aw_done, w_done;

  assign req_ready = (state_reg == IDLE) && !rd_pend_reg;

  // A channel counts as done once its valid has dropped or is handshaking now.
  assign aw_done = !awvalid_reg || m_awready;
  assign w_done  = !wvalid_reg  || m_wready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg      <= IDLE;
      rd_pend_reg    <= 1'b0;
      awaddr_reg     <= '0;
      araddr_reg     <= '0;
      wdata_reg      <= '0;
      rdata_reg      <= '0;
      awvalid_reg    <= 1'b0;
      wvalid_reg     <= 1'b0;
      bready_reg     <= 1'b0;
      arvalid_reg    <= 1'b0;
      rready_reg     <= 1'b0;
      resp_valid_reg <= 1'b0;
      resp_is_rd_reg <= 1'b0;
      resp_resp_reg  <= 2'b00;
    end else begin
      state_reg      <= state_next;
      rd_pend_reg    <= rd_pend_next;
      awaddr_reg     <= awaddr_next;
      araddr_reg     <= araddr_next;
      wdata_reg      <= wdata_next;
      rdata_reg      <= rdata_next;
      awvalid_reg    <= awvalid_next;
      wvalid_reg     <= wvalid_next;
      bready_reg     <= bready_next;
      arvalid_reg    <= arvalid_next;
      rready_reg     <= rready_next;
      resp_valid_reg <= resp_valid_next;
      resp_is_rd_reg <= resp_is_rd_next;
      resp_resp_reg  <= resp_resp_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    rd_pend_next    = rd_pend_reg;
    awaddr_next     = awaddr_reg;
    araddr_next     = araddr_reg;
    wdata_next      = wdata_reg;
    rdata_next      = rdata_reg;
    awvalid_next    = awvalid_reg;
    wvalid_next     = wvalid_reg;
    bready_next     = bready_reg;
    arvalid_next    = arvalid_reg;
    rready_next     = rready_reg;
    resp_valid_next = 1'b0;
    resp_is_rd_next = resp_is_rd_reg;
    resp_resp_next  = resp_resp_reg;

    case (state_reg)
      IDLE: begin
        if (req_ready && req_wr) begin
          awaddr_next  = req_addr;
          wdata_next   = req_wdata;
          awvalid_next = 1'b1;
          wvalid_next  = 1'b1;
          state_next   = WR;
          // A combined request reads back the word following the written one.
          if (req_rd) begin
            rd_pend_next = 1'b1;
            araddr_next  = req_addr + ADDR_WIDTH'(STRB_WIDTH);
          end
        end else if (req_ready && req_rd) begin
          araddr_next  = req_addr;
          arvalid_next = 1'b1;
          state_next   = RA;
        end
      end
      WR: begin
        if (awvalid_reg && m_awready) awvalid_next = 1'b0;
        if (wvalid_reg && m_wready)   wvalid_next  = 1'b0;
        if (aw_done && w_done) begin
          bready_next = 1'b1;
          state_next  = WB;
        end
      end
      WB: begin
        if (m_bvalid) begin
          bready_next     = 1'b0;
          resp_resp_next  = m_bresp;
          resp_is_rd_next = 1'b0;
          resp_valid_next = 1'b1;
          if (rd_pend_reg) begin
            arvalid_next = 1'b1;
            state_next   = RA;
          end else begin
            state_next = IDLE;
          end
        end
      end
      RA: begin
        if (m_arready) begin
          arvalid_next = 1'b0;
          rready_next  = 1'b1;
          state_next   = RD;
        end
      end
      RD: begin
        if (m_rvalid) begin
          rready_next     = 1'b0;
          rdata_next      = m_rdata;
          resp_resp_next  = m_rresp;
          resp_is_rd_next = 1'b1;
          resp_valid_next = 1'b1;
          rd_pend_next    = 1'b0;
          state_next      = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign m_awaddr   = awaddr_reg;
  assign m_awvalid  = awvalid_reg;
  assign m_wdata    = wdata_reg;
  assign m_wstrb    = '1;
  assign m_wvalid   = wvalid_reg;
  assign m_bready   = bready_reg;
  assign m_araddr   = araddr_reg;
  assign m_arvalid  = arvalid_reg;
  assign m_rready   = rready_reg;
  assign resp_valid = resp_valid_reg;
  assign resp_rdata = rdata_reg;
  assign resp_resp  = resp_resp_reg;
  assign resp_is_rd = resp_is_rd_reg;

endmodule

// File: tb/tb_one2axi_master.sv
// Bench for one2axi_master: AXI4-Lite slave model with programmable stalls and a
// transaction-level reference of the expected completions.
module tb_one2axi_master;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          req_wr = 1'b0, req_rd = 1'b0;
  logic          req_ready, resp_valid, resp_is_rd;
  logic [DW-1:0] resp_rdata;
  logic [1:0]    resp_resp;
  logic [AW-1:0] m_awaddr, m_araddr;
  logic          m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic          m_arvalid, m_arready, m_rvalid, m_rready;
  logic [DW-1:0] m_wdata, m_rdata;
  logic [3:0]    m_wstrb;
  logic [1:0]    m_bresp, m_rresp;

  always #5 clk = ~clk;

  one2axi_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .resetn(resetn),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wr(req_wr), .req_rd(req_rd),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_resp(resp_resp), .resp_is_rd(resp_is_rd),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  // Slave model configuration, set by the stimulus before each transaction.
  int          aw_dly = 0, w_dly = 0, ar_dly = 0, r_dly = 0;
  logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
  logic [31:0] rdata_cfg = '0;

  int          aw_cnt, w_cnt, ar_cnt, r_cnt;
  logic        aw_got, w_got, r_wait;
  logic        aw_hold_v, w_hold_v, ar_hold_v;
  logic [31:0] aw_hold_a, w_hold_d, ar_hold_a;
  int          b_hs = 0, err_aw = 0, err_w = 0, err_ar = 0;
  logic [31:0] aw_log[$], w_log[$], ar_log[$];
  logic [3:0]  strb_log[$];

  assign m_awready = m_awvalid && (aw_cnt >= aw_dly);
  assign m_wready  = m_wvalid  && (w_cnt  >= w_dly);
  assign m_arready = m_arvalid && (ar_cnt >= ar_dly);
  assign m_bresp   = bresp_cfg;
  assign m_rresp   = rresp_cfg;
  assign m_rdata   = rdata_cfg;

  always @(posedge clk) begin
    if (!resetn) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; r_wait <= 1'b0;
      m_bvalid <= 1'b0; m_rvalid <= 1'b0;
      aw_hold_v <= 1'b0; w_hold_v <= 1'b0; ar_hold_v <= 1'b0;
    end else begin
      // A valid that waited last cycle must still be up with the same payload.
      if (aw_hold_v && (!m_awvalid || m_awaddr !== aw_hold_a)) err_aw <= err_aw + 1;
      if (w_hold_v  && (!m_wvalid  || m_wdata  !== w_hold_d))  err_w  <= err_w + 1;
      if (ar_hold_v && (!m_arvalid || m_araddr !== ar_hold_a)) err_ar <= err_ar + 1;
      aw_hold_v <= m_awvalid && !m_awready; aw_hold_a <= m_awaddr;
      w_hold_v  <= m_wvalid  && !m_wready;  w_hold_d  <= m_wdata;
      ar_hold_v <= m_arvalid && !m_arready; ar_hold_a <= m_araddr;

      if (m_awvalid && m_awready) begin
        aw_cnt <= 0; aw_got <= 1'b1; aw_log.push_back(m_awaddr);
      end else if (m_awvalid) aw_cnt <= aw_cnt + 1;
      if (m_wvalid && m_wready) begin
        w_cnt <= 0; w_got <= 1'b1; w_log.push_back(m_wdata); strb_log.push_back(m_wstrb);
      end else if (m_wvalid) w_cnt <= w_cnt + 1;
      if ((aw_got || (m_awvalid && m_awready)) && (w_got || (m_wvalid && m_wready)) && !m_bvalid) begin
        m_bvalid <= 1'b1; aw_got <= 1'b0; w_got <= 1'b0;
      end
      if (m_bvalid && m_bready) begin
        m_bvalid <= 1'b0; b_hs <= b_hs + 1;
      end

      if (m_arvalid && m_arready) begin
        ar_cnt <= 0; ar_log.push_back(m_araddr);
        if (r_dly == 0) m_rvalid <= 1'b1;
        else begin r_wait <= 1'b1; r_cnt <= 1; end
      end else if (m_arvalid) ar_cnt <= ar_cnt + 1;
      if (r_wait) begin
        if (r_cnt >= r_dly) begin m_rvalid <= 1'b1; r_wait <= 1'b0; end
        else r_cnt <= r_cnt + 1;
      end
      if (m_rvalid && m_rready) m_rvalid <= 1'b0;
    end
  end

  int total = 0, bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic        is_rd;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } resp_t;

  resp_t       exp_q[$];
  logic [31:0] last_rdata = '0;

  int          n_got, aw_c, w_c, ar_c, rdy_hi, extra;
  int          o_lat[2];
  logic        o_rd[2];
  logic [1:0]  o_resp[2];
  logic [31:0] o_rdata[2];
  logic        arv_at0, ready_after;

  // Issue one request and record every completion within a bounded window.
  task automatic send_and_collect(input logic wr, input logic rd, input logic [31:0] a,
                                  input logic [31:0] d, input int n_exp);
    @(negedge clk);
    check("req_ready_before", req_ready, 1'b1);
    req_addr = a; req_wdata = d; req_wr = wr; req_rd = rd;
    n_got = 0; aw_c = 0; w_c = 0; ar_c = 0; rdy_hi = 0; extra = 0; arv_at0 = 1'b0;
    for (int i = 1; i <= 300 && n_got < n_exp; i++) begin
      @(negedge clk);
      if (i == 1) begin req_wr = 1'b0; req_rd = 1'b0; end
      if (m_awvalid) aw_c++;
      if (m_wvalid)  w_c++;
      if (m_arvalid) ar_c++;
      if (resp_valid) begin
        if (n_got == 0) arv_at0 = m_arvalid;
        o_lat[n_got] = i; o_rd[n_got] = resp_is_rd;
        o_resp[n_got] = resp_resp; o_rdata[n_got] = resp_rdata;
        n_got++;
      end else if (req_ready) rdy_hi++;
    end
    ready_after = req_ready;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (resp_valid) extra++;
    end
  endtask

  task automatic run_txn(input int kind, input logic [31:0] a, input logic [31:0] d, input string name);
    logic wr, rd;
    int   n, b0;
    logic [31:0] rd_a, v;
    logic [3:0]  s;
    resp_t e;
    wr = (kind != 1); rd = (kind != 0);
    n = (kind == 2) ? 2 : 1;
    rd_a = (kind == 2) ? a + 32'd4 : a;
    exp_q.delete();
    if (wr) begin e.is_rd = 1'b0; e.resp = bresp_cfg; e.rdata = last_rdata; exp_q.push_back(e); end
    if (rd) begin
      last_rdata = rdata_cfg;
      e.is_rd = 1'b1; e.resp = rresp_cfg; e.rdata = rdata_cfg; exp_q.push_back(e);
    end
    b0 = b_hs;
    send_and_collect(wr, rd, a, d, n);
    check({name, "_nresp"}, n_got, n);
    for (int k = 0; k < n_got && k < n; k++) begin
      check({name, "_is_rd"}, o_rd[k], exp_q[k].is_rd);
      check({name, "_resp"},  o_resp[k], exp_q[k].resp);
      check({name, "_rdata"}, o_rdata[k], exp_q[k].rdata);
    end
    check({name, "_extra_pulse"}, extra, 0);
    check({name, "_ready_low"}, rdy_hi, 0);
    check({name, "_ready_after"}, ready_after, 1'b1);
    if (wr) begin
      v = 'x; if (aw_log.size() > 0) v = aw_log.pop_front();
      check({name, "_awaddr"}, v, a);
      v = 'x; if (w_log.size() > 0) v = w_log.pop_front();
      check({name, "_wdata"}, v, d);
      s = 'x; if (strb_log.size() > 0) s = strb_log.pop_front();
      check({name, "_wstrb"}, s, 4'hF);
      check({name, "_b_hs"}, b_hs - b0, 1);
    end
    if (rd) begin
      v = 'x; if (ar_log.size() > 0) v = ar_log.pop_front();
      check({name, "_araddr"}, v, rd_a);
    end
    $display("txn %s kind=%0d addr=%h wdata=%h responses=%0d first_lat=%0d", name, kind, a, d, n_got, o_lat[0]);
  endtask

  initial begin
    int          kind, cnt;
    logic [31:0] ra, rd_v;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ctrl", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, resp_valid, resp_is_rd}, 7'd0);
    check("rst_data", {m_awaddr, m_araddr}, 64'd0);
    check("rst_wdata_rdata", {m_wdata, resp_rdata}, 64'd0);
    check("rst_resp", resp_resp, 2'b00);
    check("rst_wstrb", m_wstrb, 4'hF);
    check("rst_req_ready", req_ready, 1'b1);
    resetn = 1'b1;

    // Single write against an always-ready slave
    run_txn(0, 32'h0000_0104, 32'h1122_3344, "wr_fast");
    check("wr_fast_latency", o_lat[0], 3);
    check("wr_fast_aw_cycles", aw_c, 1);
    check("wr_fast_w_cycles", w_c, 1);

    // Read with AR stalled 4 cycles
    ar_dly = 4; rdata_cfg = 32'h5566_7788;
    run_txn(1, 32'h0000_0200, 32'h0, "rd_slow_ar");
    check("rd_slow_ar_cycles", ar_c, 5);
    check("rd_slow_latency", o_lat[0], 7);
    ar_dly = 0;

    // W accepted three cycles before AW
    aw_dly = 3;
    run_txn(0, 32'h0000_0300, 32'hCAFE_F00D, "wr_w_first");
    check("wr_w_first_aw_cycles", aw_c, 4);
    check("wr_w_first_w_cycles", w_c, 1);
    aw_dly = 0;

    // Combined write + read
    rdata_cfg = 32'h0BAD_F00D;
    run_txn(2, 32'h0000_0108, 32'hA5A5_5A5A, "wr_rd");
    check("wr_rd_lat_wr", o_lat[0], 3);
    check("wr_rd_lat_rd", o_lat[1], 5);
    check("wr_rd_no_idle_gap", arv_at0, 1'b1);

    // Error responses pass through
    bresp_cfg = 2'b10;
    run_txn(0, 32'h0000_0400, 32'h1357_9BDF, "wr_slverr");
    bresp_cfg = 2'b00; rresp_cfg = 2'b11; rdata_cfg = 32'h2468_ACE0;
    run_txn(1, 32'h0000_0404, 32'h0, "rd_decerr");
    rresp_cfg = 2'b00;

    // Reset while waiting in the R phase
    r_dly = 20; rdata_cfg = 32'hDEAD_BEEF;
    @(negedge clk);
    req_addr = 32'h0000_0500; req_rd = 1'b1;
    @(negedge clk);
    req_rd = 1'b0;
    @(negedge clk);
    check("rst_mid_rready_before", m_rready, 1'b1);
    #2 resetn = 1'b0;
    #1;
    check("rst_mid_ctrl", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, resp_valid, resp_is_rd}, 7'd0);
    check("rst_mid_req_ready", req_ready, 1'b1);
    check("rst_mid_rdata", resp_rdata, 32'd0);
    ra = 'x; if (ar_log.size() > 0) ra = ar_log.pop_front();
    check("rst_mid_araddr", ra, 32'h0000_0500);
    @(negedge clk); @(negedge clk);
    resetn = 1'b1;
    last_rdata = '0;
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (resp_valid) cnt++;
    end
    check("rst_mid_no_resp", cnt, 0);
    check("rst_mid_ready_after", req_ready, 1'b1);
    $display("txn rst_mid addr=00000500 responses=%0d", cnt);
    r_dly = 0;

    // Randomized traffic
    for (int t = 0; t < 24; t++) begin
      kind = $urandom_range(0, 2);
      aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3);
      ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3);
      bresp_cfg = 2'($urandom_range(0, 3)); rresp_cfg = 2'($urandom_range(0, 3));
      rd_v = $urandom; rdata_cfg = rd_v;
      ra = {20'd0, 10'($urandom_range(0, 1023)), 2'b00};
      run_txn(kind, ra, $urandom, "rand");
    end

    check("aw_stable", err_aw, 0);
    check("w_stable", err_w, 0);
    check("ar_stable", err_ar, 0);
    check("logs_drained", aw_log.size() + w_log.size() + ar_log.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
